// File: rtl/opsg_stereo_if.sv
// Shared CPU-side write bus for the stereo OPSG: register strobe, pan strobe,
// bank select and the write data byte.
interface opsg_stereo_if;
  logic       n_wr;
  logic       n_pan_wr;
  logic [1:0] bank;
  logic [7:0] data;

  modport master (output n_wr, output n_pan_wr, output bank, output data);
  modport slave  (input  n_wr, input  n_pan_wr, input  bank, input  data);
endinterface

// File: rtl/opsg_stereo.sv
// Multi-bank SN76489-style sound generator with per-bank pan and a saturating
// stereo mixer. Each bank holds 3 square-wave tones and 1 LFSR noise channel.
// All channels advance on a common prescaled tick; the mixed sample appears two
// clocks after each tick together with a one-cycle sample_strobe.
module opsg_stereo #(
  parameter int NUM_BANKS  = 1,
  parameter int CLK_DIV    = 4,
  parameter int MAX_VOLUME = 2048,
  parameter int BANK_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  opsg_stereo_if.slave           bus,
  output logic [4*NUM_BANKS-1:0] ch_out,
  output logic [15:0]            audio_left,
  output logic [15:0]            audio_right,
  output logic                   sample_strobe
);
  localparam int PRESC_MAX = 16 * CLK_DIV - 1;
  localparam int PW        = $clog2(16 * CLK_DIV);

  logic [BANK_W-1:0] bank_sel;
  logic              bank_ok, n_wr_q, n_pan_q, wr_go, pan_go;
  logic [PW-1:0]     presc;
  logic              tick, tick_d1, sum_v;

  logic [9:0]  period   [NUM_BANKS][3];
  logic [9:0]  cnt      [NUM_BANKS][3];
  logic [9:0]  cnt_n    [NUM_BANKS][3];
  logic [2:0]  tone_out [NUM_BANKS];
  logic [2:0]  out_n    [NUM_BANKS];
  logic [3:0]  att      [NUM_BANKS][4];
  logic [2:0]  nctrl    [NUM_BANKS];
  logic [9:0]  ncnt     [NUM_BANKS];
  logic [9:0]  ncnt_n   [NUM_BANKS];
  logic        nclk     [NUM_BANKS];
  logic        nclk_n   [NUM_BANKS];
  logic        shift_en [NUM_BANKS];
  logic [15:0] lfsr     [NUM_BANKS];
  logic [15:0] lfsr_n   [NUM_BANKS];
  logic [7:0]  pan      [NUM_BANKS];
  logic [1:0]  latch_ch [NUM_BANKS];
  logic        latch_att[NUM_BANKS];
  logic        wr_hit   [NUM_BANKS];
  logic        pan_hit  [NUM_BANKS];
  logic        noise_wr [NUM_BANKS];
  logic [1:0]  wr_ch    [NUM_BANKS];
  logic        wr_att   [NUM_BANKS];

  logic [31:0] mix_l, mix_r, sum_l, sum_r;

  assign bank_sel = bus.bank;
  assign bank_ok  = int'(bank_sel) < NUM_BANKS;
  assign wr_go    = n_wr_q & ~bus.n_wr;
  assign pan_go   = n_pan_q & ~bus.n_pan_wr;
  assign tick     = (presc == '0);

  // Half-period counter: period 0/1 parks the output high.
  function automatic logic [10:0] tone_step(input logic [9:0] c, input logic [9:0] p,
                                            input logic o);
    if (p <= 10'd1)      return {10'd0, 1'b1};
    else if (c == 10'd0) return {p - 10'd1, ~o};
    else                 return {c - 10'd1, o};
  endfunction

  function automatic logic [9:0] noise_period(input logic [1:0] r);
    case (r)
      2'd0:    return 10'h010;
      2'd1:    return 10'h020;
      default: return 10'h040;
    endcase
  endfunction

  // Attenuation 0 is treated as unity gain so the level equals MAX_VOLUME exactly.
  function automatic logic [31:0] level(input logic [3:0] a);
    logic [16:0] f;
    logic [63:0] p;
    case (a)
      4'd0:  f = 17'd65536;  4'd1:  f = 17'd52057;  4'd2:  f = 17'd41350;
      4'd3:  f = 17'd32846;  4'd4:  f = 17'd26090;  4'd5:  f = 17'd20724;
      4'd6:  f = 17'd16462;  4'd7:  f = 17'd13076;  4'd8:  f = 17'd10387;
      4'd9:  f = 17'd8250;   4'd10: f = 17'd6554;   4'd11: f = 17'd5206;
      4'd12: f = 17'd4135;   4'd13: f = 17'd3285;   4'd14: f = 17'd2609;
      default: f = 17'd0;
    endcase
    p = 64'(MAX_VOLUME) * {47'd0, f};
    return p[47:16];
  endfunction

  // Per-bank write decode; a data byte reuses the bank's latched channel/type.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      wr_hit[b]   = wr_go && bank_ok && (bank_sel == BANK_W'(b));
      pan_hit[b]  = pan_go && bank_ok && (bank_sel == BANK_W'(b));
      wr_ch[b]    = bus.data[7] ? bus.data[6:5] : latch_ch[b];
      wr_att[b]   = bus.data[7] ? bus.data[4] : latch_att[b];
      noise_wr[b] = wr_hit[b] && !wr_att[b] && (wr_ch[b] == 2'd3);
    end
  end

  // Next tone/noise counter state and LFSR shift for the coming tick.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int c = 0; c < 3; c++)
        {cnt_n[b][c], out_n[b][c]} = tone_step(cnt[b][c], period[b][c], tone_out[b][c]);
      {ncnt_n[b], nclk_n[b]} = tone_step(ncnt[b], noise_period(nctrl[b][1:0]), nclk[b]);
      shift_en[b] = (nctrl[b][1:0] == 2'b11) ? (~tone_out[b][2] & out_n[b][2])
                                              : (~nclk[b] & nclk_n[b]);
      lfsr_n[b] = {(nctrl[b][2] ? (lfsr[b][0] ^ lfsr[b][3]) : lfsr[b][0]), lfsr[b][15:1]};
    end
  end

  // Register file, prescaler and channel generators.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_wr_q  <= 1'b1;
      n_pan_q <= 1'b1;
      presc   <= PW'(PRESC_MAX);
      tick_d1 <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int c = 0; c < 3; c++) begin
          period[b][c] <= '0;
          cnt[b][c]    <= '0;
        end
        for (int c = 0; c < 4; c++) att[b][c] <= 4'hF;
        tone_out[b]  <= '0;
        nctrl[b]     <= '0;
        ncnt[b]      <= '0;
        nclk[b]      <= 1'b0;
        lfsr[b]      <= 16'h8000;
        pan[b]       <= 8'hFF;
        latch_ch[b]  <= 2'd0;
        latch_att[b] <= 1'b0;
      end
    end else begin
      n_wr_q  <= bus.n_wr;
      n_pan_q <= bus.n_pan_wr;
      presc   <= tick ? PW'(PRESC_MAX) : presc - 1'b1;
      tick_d1 <= tick;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (pan_hit[b]) pan[b] <= bus.data;
        if (wr_hit[b] && bus.data[7]) begin
          latch_ch[b]  <= bus.data[6:5];
          latch_att[b] <= bus.data[4];
        end
        if (wr_hit[b] && wr_att[b])
          for (int c = 0; c < 4; c++)
            if (wr_ch[b] == 2'(c)) att[b][c] <= bus.data[3:0];
        if (noise_wr[b]) nctrl[b] <= bus.data[2:0];
        if (wr_hit[b] && !wr_att[b])
          for (int c = 0; c < 3; c++)
            if (wr_ch[b] == 2'(c)) begin
              if (bus.data[7]) period[b][c][3:0] <= bus.data[3:0];
              else             period[b][c][9:4] <= bus.data[5:0];
            end
        if (tick) begin
          for (int c = 0; c < 3; c++) cnt[b][c] <= cnt_n[b][c];
          tone_out[b] <= out_n[b];
          ncnt[b]     <= ncnt_n[b];
          nclk[b]     <= nclk_n[b];
        end
        if (noise_wr[b])                lfsr[b] <= 16'h8000;
        else if (tick && shift_en[b])   lfsr[b] <= lfsr_n[b];
      end
    end
  end

  // Raw channel bits: tones in the low three bits of each nibble, noise on top.
  always_comb begin
    ch_out = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      ch_out[4*b +: 3] = tone_out[b];
      ch_out[4*b + 3]  = lfsr[b][0];
    end
  end

  // Stereo sum over active, panned channels; wide enough that it never wraps.
  always_comb begin
    mix_l = '0;
    mix_r = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int c = 0; c < 4; c++) begin
        if (ch_out[4*b + c] && pan[b][4 + c]) mix_l = mix_l + level(att[b][c]);
        if (ch_out[4*b + c] && pan[b][c])     mix_r = mix_r + level(att[b][c]);
      end
  end

  // Two-stage output pipeline: capture the sum, then saturate into the sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_l         <= '0;
      sum_r         <= '0;
      sum_v         <= 1'b0;
      audio_left    <= '0;
      audio_right   <= '0;
      sample_strobe <= 1'b0;
    end else begin
      sum_v         <= tick_d1;
      sample_strobe <= sum_v;
      if (tick_d1) begin
        sum_l <= mix_l;
        sum_r <= mix_r;
      end
      if (sum_v) begin
        audio_left  <= (sum_l > 32'hFFFF) ? 16'hFFFF : sum_l[15:0];
        audio_right <= (sum_r > 32'hFFFF) ? 16'hFFFF : sum_r[15:0];
      end
    end
  end
endmodule

// File: tb/tb_opsg_stereo.sv
// Bench for opsg_stereo: a single-bank instance (2048 full scale) and a
// four-bank instance (8192 full scale), both with CLK_DIV=1 (tick = 16 clk).
module tb_opsg_stereo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  opsg_stereo_if bus_a ();
  opsg_stereo_if bus_b ();

  logic [3:0]  ch_a;
  logic [15:0] ch_b;
  logic [15:0] left_a, right_a, left_b, right_b;
  logic        strobe_a, strobe_b;

  typedef struct { logic [15:0] l; logic [15:0] r; } exp_t;
  exp_t exp_q[$];

  opsg_stereo #(.NUM_BANKS(1), .CLK_DIV(1), .MAX_VOLUME(2048), .BANK_W(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .ch_out(ch_a),
    .audio_left(left_a), .audio_right(right_a), .sample_strobe(strobe_a));

  opsg_stereo #(.NUM_BANKS(4), .CLK_DIV(1), .MAX_VOLUME(8192), .BANK_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .ch_out(ch_b),
    .audio_left(left_b), .audio_right(right_b), .sample_strobe(strobe_b));

  always #5 clk = ~clk;

  // Free-running cycle count for interval measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic bus_write(input int sel, input bit is_pan, input logic [1:0] bk,
                           input logic [7:0] d);
    @(negedge clk);
    if (sel == 0) begin
      bus_a.bank = bk; bus_a.data = d;
      if (is_pan) bus_a.n_pan_wr = 1'b0; else bus_a.n_wr = 1'b0;
    end else begin
      bus_b.bank = bk; bus_b.data = d;
      if (is_pan) bus_b.n_pan_wr = 1'b0; else bus_b.n_wr = 1'b0;
    end
    @(negedge clk);
    bus_a.n_wr = 1'b1; bus_a.n_pan_wr = 1'b1;
    bus_b.n_wr = 1'b1; bus_b.n_pan_wr = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    e.l = l;
    e.r = r;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the next sample that has
  // the requested tone-0 phase (dut_a) or simply the next sample (dut_b).
  task automatic expect_sample(input int sel, input bit want_hi, input string tag);
    exp_t e;
    bit   hit = 1'b0;
    e = exp_q.pop_front();
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(posedge clk); #1;
      if (sel == 0) hit = strobe_a && (ch_a[0] == want_hi);
      else          hit = strobe_b;
    end
    if (!hit) chk_eq({tag, "_timeout"}, 0, 1);
    else if (sel == 0) begin
      chk_eq({tag, "_left"},  {16'd0, left_a},  {16'd0, e.l});
      chk_eq({tag, "_right"}, {16'd0, right_a}, {16'd0, e.r});
    end else begin
      chk_eq({tag, "_left"},  {16'd0, left_b},  {16'd0, e.l});
      chk_eq({tag, "_right"}, {16'd0, right_b}, {16'd0, e.r});
    end
  endtask

  task automatic wait_tone0_edge(input string tag, output int t);
    logic prev;
    bit   hit = 1'b0;
    @(posedge clk); #1;
    prev = ch_a[0];
    t = cyc;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge clk); #1;
      if (ch_a[0] != prev) begin hit = 1'b1; t = cyc; end
    end
    if (!hit) chk_eq({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int  t1, t2, t3, w;
    bit  hit;
    bus_a.n_wr = 1'b1; bus_a.n_pan_wr = 1'b1; bus_a.bank = 2'd0; bus_a.data = 8'h00;
    bus_b.n_wr = 1'b1; bus_b.n_pan_wr = 1'b1; bus_b.bank = 2'd0; bus_b.data = 8'h00;

    // Reset held for three clocks.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_eq("reset_no_strobe", {31'd0, strobe_a | strobe_b}, 0);
    end
    chk_eq("reset_ch_out_a", {28'd0, ch_a}, 0);
    chk_eq("reset_ch_out_b", {16'd0, ch_b}, 0);
    chk_eq("reset_audio_a", {left_a, right_a}, 0);
    chk_eq("reset_audio_b", {left_b, right_b}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Latch + data byte: period 0x033 gives a 51-tick half period.
    bus_write(0, 0, 2'd0, 8'h83);
    bus_write(0, 0, 2'd0, 8'h03);
    wait_tone0_edge("tone_edge1", t1);
    wait_tone0_edge("tone_edge2", t2);
    wait_tone0_edge("tone_edge3", t3);
    chk_eq("tone_half_period_1", t2 - t1, 816);
    chk_eq("tone_half_period_2", t3 - t2, 816);

    // Volume: att 0 -> 2048 while high, 0 while low; att 1 -> 1626.
    bus_write(0, 0, 2'd0, 8'h90);
    repeat (40) @(posedge clk);
    push_exp(16'd2048, 16'd2048);
    expect_sample(0, 1'b1, "vol_att0_high");
    push_exp(16'd0, 16'd0);
    expect_sample(0, 1'b0, "vol_att0_low");
    bus_write(0, 0, 2'd0, 8'h91);
    repeat (40) @(posedge clk);
    push_exp(16'd1626, 16'd1626);
    expect_sample(0, 1'b1, "vol_att1_high");

    // Pan: right only; then writes to a nonexistent bank are ignored.
    bus_write(0, 0, 2'd0, 8'h90);
    bus_write(0, 1, 2'd0, 8'h0F);
    repeat (40) @(posedge clk);
    push_exp(16'd0, 16'd2048);
    expect_sample(0, 1'b1, "pan_right_only");
    bus_write(0, 1, 2'd3, 8'hF0);
    bus_write(0, 0, 2'd3, 8'h9F);
    repeat (40) @(posedge clk);
    push_exp(16'd0, 16'd2048);
    expect_sample(0, 1'b1, "pan_bank3_ignored");

    // Saturation on the four-bank instance: period 1 tones at att 0.
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < 3; c++) begin
        bus_write(1, 0, 2'(b), 8'h81 | 8'(c << 5));
        bus_write(1, 0, 2'(b), 8'h00);
      end
    bus_write(1, 0, 2'd0, 8'h90);
    repeat (40) @(posedge clk);
    push_exp(16'd8192, 16'd8192);
    expect_sample(1, 1'b1, "mix_one_channel");
    for (int k = 1; k < 12; k++) begin
      bus_write(1, 0, 2'(k / 3), 8'h90 | 8'((k % 3) << 5));
      if (k == 6 || k == 7) begin
        repeat (40) @(posedge clk);
        if (k == 6) push_exp(16'd57344, 16'd57344);
        else        push_exp(16'hFFFF, 16'hFFFF);
        expect_sample(1, 1'b1, (k == 6) ? "mix_seven_channels" : "mix_eight_saturate");
      end
    end
    repeat (40) @(posedge clk);
    push_exp(16'hFFFF, 16'hFFFF);
    expect_sample(1, 1'b1, "mix_twelve_saturate");

    // Noise: white, rate 00 -> first rise after 15 shifts (about 480 ticks).
    bus_write(0, 0, 2'd0, 8'hA1);
    bus_write(0, 0, 2'd0, 8'hB0);
    bus_write(0, 0, 2'd0, 8'hE4);
    w = cyc;
    #1;
    chk_eq("noise_lfsr_reloaded", {31'd0, ch_a[3]}, 0);
    hit = 1'b0;
    for (int i = 0; i < 9000 && !hit; i++) begin
      @(posedge clk); #1;
      if (ch_a[3]) hit = 1'b1;
    end
    if (!hit) chk_eq("noise_rise_timeout", 0, 1);
    else      chk_eq("noise_rise_window", {31'd0, (cyc - w >= 7150) && (cyc - w <= 7700)}, 1);

    // Reset mid-run clears everything on the next cycle.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_eq("midrst_ch_out", {28'd0, ch_a}, 0);
    chk_eq("midrst_audio", {left_a, right_a}, 0);
    chk_eq("midrst_strobe", {31'd0, strobe_a}, 0);
    bus_write(0, 0, 2'd0, 8'h90);
    bus_write(0, 0, 2'd0, 8'hB0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    push_exp(16'd0, 16'd0);
    expect_sample(0, 1'b1, "write_during_rst_discarded");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
